// File: rtl/lock_controller_if.sv
// PIN entry channel from the keypad decoder into the lock controller.
// validPin is a single-cycle strobe with no back-pressure; userPin is only meaningful while validPin is high.
interface lock_controller_if;
    logic [15:0] userPin;
    logic        validPin;

    modport master (output userPin, output validPin);
    modport slave  (input  userPin, input  validPin);
endinterface

// File: rtl/lock_controller.sv
// Keypad lock state machine: PIN check, timed lockout after repeated failures,
// auto-relock after a quiet period, and two-entry PIN change.
module lock_controller #(
    parameter logic [15:0] DEFAULT_PIN  = 16'h4321,
    parameter int          MAX_ATTEMPTS = 3,
    parameter int          LOCKOUT_SECS = 30,
    parameter int          UNLOCK_SECS  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick_1Hz,
    lock_controller_if.slave         pin_bus,
    input  logic [1:0]               sw,
    output logic                     unlocked,
    output logic                     lockout,
    output logic [1:0]               state,
    output logic [1:0]               attemptsLeft,
    output logic [5:0]               secsLeft,
    output logic                     okPulse,
    output logic                     failPulse,
    output logic [15:0]              storedPin
);

    typedef enum logic [1:0] {
        LOCKED         = 2'd0,
        UNLOCKED       = 2'd1,
        CHANGE_CONFIRM = 2'd2,
        LOCKOUT        = 2'd3
    } lock_state_e;

    localparam logic [1:0] MAX_ATT   = 2'(MAX_ATTEMPTS);
    localparam logic [5:0] LOCK_S    = 6'(LOCKOUT_SECS);
    localparam logic [5:0] UNLOCK_S  = 6'(UNLOCK_SECS);

    lock_state_e cur_state, nxt_state;
    logic [15:0] stored_q, stored_d;
    logic [15:0] cand_q, cand_d;
    logic [1:0]  att_q, att_d;
    logic [5:0]  secs_q, secs_d;
    logic        ok_q, ok_d;
    logic        fail_q, fail_d;
    logic        well_formed;

    assign well_formed = (pin_bus.userPin[3:0]   <= 4'd9) &&
                         (pin_bus.userPin[7:4]   <= 4'd9) &&
                         (pin_bus.userPin[11:8]  <= 4'd9) &&
                         (pin_bus.userPin[15:12] <= 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= LOCKED;
            stored_q  <= DEFAULT_PIN;
            cand_q    <= 16'h0000;
            att_q     <= MAX_ATT;
            secs_q    <= 6'd0;
            ok_q      <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            stored_q  <= stored_d;
            cand_q    <= cand_d;
            att_q     <= att_d;
            secs_q    <= secs_d;
            ok_q      <= ok_d;
            fail_q    <= fail_d;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        stored_d  = stored_q;
        cand_d    = cand_q;
        att_d     = att_q;
        secs_d    = secs_q;
        ok_d      = 1'b0;
        fail_d    = 1'b0;
        case (cur_state)
            LOCKED: begin
                if (pin_bus.validPin) begin
                    if (pin_bus.userPin == stored_q) begin
                        nxt_state = UNLOCKED;
                        att_d     = MAX_ATT;
                        secs_d    = UNLOCK_S;
                        ok_d      = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                        if (att_q != 2'd0) att_d = att_q - 2'd1;
                        if (att_q == 2'd1) begin
                            nxt_state = LOCKOUT;
                            secs_d    = LOCK_S;
                        end
                    end
                end
            end
            UNLOCKED: begin
                // Manual lock beats PIN entry, and any PIN activity beats the tick.
                if (sw[1]) begin
                    nxt_state = LOCKED;
                    secs_d    = 6'd0;
                end else if (pin_bus.validPin && sw[0]) begin
                    if (well_formed) begin
                        cand_d    = pin_bus.userPin;
                        nxt_state = CHANGE_CONFIRM;
                    end else begin
                        fail_d = 1'b1;
                        secs_d = UNLOCK_S;
                    end
                end else if (pin_bus.validPin) begin
                    secs_d = UNLOCK_S;
                end else if (tick_1Hz) begin
                    if (secs_q == 6'd1) begin
                        nxt_state = LOCKED;
                        secs_d    = 6'd0;
                    end else if (secs_q != 6'd0) begin
                        secs_d = secs_q - 6'd1;
                    end
                end
            end
            CHANGE_CONFIRM: begin
                if (sw[1]) begin
                    nxt_state = LOCKED;
                    secs_d    = 6'd0;
                end else if (!sw[0]) begin
                    nxt_state = UNLOCKED;
                    secs_d    = UNLOCK_S;
                end else if (pin_bus.validPin) begin
                    nxt_state = UNLOCKED;
                    secs_d    = UNLOCK_S;
                    if (pin_bus.userPin == cand_q) begin
                        stored_d = cand_q;
                        ok_d     = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                    end
                end
            end
            LOCKOUT: begin
                if (tick_1Hz) begin
                    if (secs_q == 6'd1) begin
                        nxt_state = LOCKED;
                        att_d     = MAX_ATT;
                        secs_d    = 6'd0;
                    end else if (secs_q != 6'd0) begin
                        secs_d = secs_q - 6'd1;
                    end
                end
            end
        endcase
    end

    assign state        = cur_state;
    assign unlocked     = (cur_state == UNLOCKED) || (cur_state == CHANGE_CONFIRM);
    assign lockout      = (cur_state == LOCKOUT);
    assign attemptsLeft = att_q;
    assign secsLeft     = secs_q;
    assign okPulse      = ok_q;
    assign failPulse    = fail_q;
    assign storedPin    = stored_q;

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: directed walk through the lock's scenarios, then
// random PIN/tick/switch traffic scored cycle by cycle against a rule-level model.
module tb_lock_controller;

    localparam int W = 30;

    logic        clk;
    logic        rst;
    logic        tick_1Hz;
    logic [1:0]  sw;
    logic        unlocked, lockout, okPulse, failPulse;
    logic [1:0]  state, attemptsLeft;
    logic [5:0]  secsLeft;
    logic [15:0] storedPin;

    lock_controller_if pin_bus ();

    lock_controller dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1Hz     (tick_1Hz),
        .pin_bus      (pin_bus.slave),
        .sw           (sw),
        .unlocked     (unlocked),
        .lockout      (lockout),
        .state        (state),
        .attemptsLeft (attemptsLeft),
        .secsLeft     (secsLeft),
        .okPulse      (okPulse),
        .failPulse    (failPulse),
        .storedPin    (storedPin)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // rule-level reference model: modes 0 locked, 1 open, 2 confirming, 3 lockout
    int          m_mode;
    int          m_att;
    int          m_secs;
    logic [15:0] m_stored;
    logic [15:0] m_cand;
    bit          m_ok, m_fail;

    function automatic bit pin_digits_ok(input logic [15:0] p);
        for (int i = 0; i < 4; i++)
            if (((int'(p) >> (4 * i)) & 15) > 9) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_att = 3; m_secs = 0;
        m_stored = 16'h4321; m_cand = 16'h0000;
        m_ok = 0; m_fail = 0;
    endtask

    task automatic model_step(input bit t, input bit v, input logic [15:0] p, input logic [1:0] s);
        m_ok = 0; m_fail = 0;
        if (m_mode == 0) begin
            if (v && p == m_stored) begin
                m_mode = 1; m_att = 3; m_secs = 10; m_ok = 1;
            end else if (v) begin
                m_fail = 1;
                if (m_att > 0) m_att = m_att - 1;
                if (m_att == 0) begin m_mode = 3; m_secs = 30; end
            end
        end else if (m_mode == 1) begin
            if (s[1]) begin
                m_mode = 0; m_secs = 0;
            end else if (v && s[0] && pin_digits_ok(p)) begin
                m_cand = p; m_mode = 2;
            end else if (v) begin
                m_fail = s[0];
                m_secs = 10;
            end else if (t && m_secs > 0) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) m_mode = 0;
            end
        end else if (m_mode == 2) begin
            if (s[1]) begin
                m_mode = 0; m_secs = 0;
            end else if (!s[0]) begin
                m_mode = 1; m_secs = 10;
            end else if (v) begin
                if (p == m_cand) begin m_stored = m_cand; m_ok = 1; end
                else m_fail = 1;
                m_mode = 1; m_secs = 10;
            end
        end else begin
            if (t && m_secs > 0) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin m_mode = 0; m_att = 3; end
            end
        end
        exp_q.push_back({2'(m_mode), 2'(m_att), 6'(m_secs), m_ok, m_fail,
                         (m_mode == 1 || m_mode == 2), (m_mode == 3), m_stored});
    endtask

    task automatic scoreboard_check();
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("state",    32'(state),        32'(e[29:28]));
        check("attempts", 32'(attemptsLeft), 32'(e[27:26]));
        check("secs",     32'(secsLeft),     32'(e[25:20]));
        check("ok",       32'(okPulse),      32'(e[19]));
        check("fail",     32'(failPulse),    32'(e[18]));
        check("unlocked", 32'(unlocked),     32'(e[17]));
        check("lockout",  32'(lockout),      32'(e[16]));
        check("stored",   32'(storedPin),    32'(e[15:0]));
        check("pulse_excl", 32'(okPulse & failPulse), 32'd0);
    endtask

    // driver tasks: entered and left at a falling edge
    task automatic drive_cycle(input bit t, input bit v, input logic [15:0] p, input logic [1:0] s);
        tick_1Hz = t; pin_bus.validPin = v; pin_bus.userPin = p; sw = s;
        @(posedge clk);
        model_step(t, v, p, s);
        #1;
        scoreboard_check();
        @(negedge clk);
        tick_1Hz = 1'b0; pin_bus.validPin = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] p, input logic [1:0] s);
        drive_cycle(1'b0, 1'b1, p, s);
    endtask

    task automatic ticks(input int n, input logic [1:0] s);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 16'h0, s);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},    32'(state),        32'd0);
        check({tag, "_stored"},   32'(storedPin),    32'h4321);
        check({tag, "_attempts"}, 32'(attemptsLeft), 32'd3);
        check({tag, "_secs"},     32'(secsLeft),     32'd0);
        check({tag, "_pulses"},   32'({okPulse, failPulse}), 32'd0);
        check({tag, "_flags"},    32'({unlocked, lockout}),  32'd0);
    endtask

    // asserted between clock edges; values must appear without any edge
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_reset_values(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] p;
        logic [1:0]  s;
        bit          t, v;
        rst = 1'b1; tick_1Hz = 1'b0; sw = 2'b00;
        pin_bus.validPin = 1'b0; pin_bus.userPin = 16'h0;
        model_reset();
        #3 check_reset_values("por");
        @(negedge clk);
        rst = 1'b0;

        // correct PIN, then auto-relock after exactly ten ticks
        strobe(16'h4321, 2'b00);
        check("open_state", 32'(state), 32'd1);
        check("open_ok",    32'(okPulse), 32'd1);
        check("open_secs",  32'(secsLeft), 32'd10);
        drive_cycle(1'b0, 1'b0, 16'h0, 2'b00);
        check("ok_width", 32'(okPulse), 32'd0);
        ticks(9, 2'b00);
        check("relock_9th", 32'(state), 32'd1);
        ticks(1, 2'b00);
        check("relock_10th", 32'(state), 32'd0);

        // three wrong entries -> lockout
        strobe(16'h1111, 2'b00);
        check("att_after1", 32'(attemptsLeft), 32'd2);
        strobe(16'h1111, 2'b00);
        check("att_after2", 32'(attemptsLeft), 32'd1);
        strobe(16'h1111, 2'b00);
        check("lockout_state", 32'(state), 32'd3);
        check("lockout_secs",  32'(secsLeft), 32'd30);
        strobe(16'h4321, 2'b00);
        check("lockout_ignores", 32'({state, okPulse, failPulse}), 32'({2'd3, 2'b00}));
        ticks(29, 2'b00);
        check("lockout_29", 32'(state), 32'd3);
        ticks(1, 2'b00);
        check("lockout_end_state", 32'(state), 32'd0);
        check("lockout_end_att",   32'(attemptsLeft), 32'd3);

        // PIN change
        strobe(16'h4321, 2'b00);
        strobe(16'h9876, 2'b01);
        check("chg_confirm", 32'(state), 32'd2);
        strobe(16'h9876, 2'b01);
        check("chg_done", 32'({state, okPulse}), 32'({2'd1, 1'b1}));
        check("chg_stored", 32'(storedPin), 32'h9876);
        drive_cycle(1'b0, 1'b0, 16'h0, 2'b10);
        strobe(16'h4321, 2'b00);
        check("old_pin_rejected", 32'(failPulse), 32'd1);
        strobe(16'h9876, 2'b00);
        check("new_pin_opens", 32'(state), 32'd1);

        // confirm mismatch and malformed entry
        strobe(16'h9876, 2'b01);
        strobe(16'h9875, 2'b01);
        check("mismatch_fail",   32'({state, failPulse}), 32'({2'd1, 1'b1}));
        check("mismatch_stored", 32'(storedPin), 32'h9876);
        strobe(16'h12A4, 2'b01);
        check("malformed_fail", 32'({state, failPulse}), 32'({2'd1, 1'b1}));

        // manual lock beats a same-cycle strobe and tick
        drive_cycle(1'b1, 1'b1, 16'h9876, 2'b10);
        check("prio_lock", 32'({state, secsLeft, okPulse, failPulse}), 32'd0);

        // reset in the middle of a lockout
        for (int i = 0; i < 3; i++) strobe(16'h0000, 2'b00);
        check("pre_rst_lockout", 32'(state), 32'd3);
        async_reset("mid_lockout");

        // reset in the middle of a change
        strobe(16'h4321, 2'b00);
        strobe(16'h5555, 2'b01);
        async_reset("mid_change");

        // random traffic
        s = 2'b00;
        for (int c = 0; c < 4000; c++) begin
            case ($urandom_range(0, 4))
                0: p = m_stored;
                1: p = m_cand;
                2: p = 16'h4321;
                3: p = 16'($urandom);
                default: begin
                    p = 16'($urandom);
                    p[3:0] = 4'($urandom_range(10, 15));
                end
            endcase
            v = ($urandom_range(0, 3) == 0);
            t = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) s[0] = ~s[0];
            s[1] = ($urandom_range(0, 29) == 0);
            drive_cycle(t, v, p, s);
            if ($urandom_range(0, 799) == 0) async_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
